// File: rtl/seg7_capture.sv
// seg7_capture: rebuilds a 32-bit hex value, decimal points and blank flags by
// watching a multiplexed, active-low 8-digit seven-segment display bus.
`default_nettype none

module seg7_capture #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [7:0]  AN,
  input  logic [7:0]  segment,
  output logic [31:0] disp_num,
  output logic [7:0]  point,
  output logic [7:0]  blank,
  output logic        frame_valid,
  output logic        err
);

  localparam logic [7:0] HIT_COUNT = 8'(STABLE_CYCLES - 2);

  logic [7:0]  an_q, seg_q, an_prev, seg_prev;
  logic [7:0]  stab_cnt;
  logic [7:0]  mask, mask_next;
  logic [31:0] stage_num;
  logic [7:0]  stage_pt, stage_blank;

  logic        same, one_low, capture, glyph_ok, is_blank;
  logic [7:0]  sel;
  logic [2:0]  idx;
  logic [6:0]  glyph;
  logic [3:0]  nib;

  // Input register plus a delayed copy; stability is judged on registered data only.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      an_q     <= 8'h00;
      seg_q    <= 8'h00;
      an_prev  <= 8'h00;
      seg_prev <= 8'h00;
    end else begin
      an_q     <= AN;
      seg_q    <= segment;
      an_prev  <= an_q;
      seg_prev <= seg_q;
    end
  end

  assign same = ({an_q, seg_q} == {an_prev, seg_prev});

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stab_cnt <= 8'h00;
    end else if (!same) begin
      stab_cnt <= 8'h00;
    end else if (stab_cnt != 8'hFF) begin
      stab_cnt <= stab_cnt + 8'h01;
    end
  end

  assign sel     = ~an_q;
  assign one_low = (sel != 8'h00) && ((sel & (sel - 8'h01)) == 8'h00);
  // The counter passes HIT_COUNT exactly once per held value, so this fires once.
  assign capture = same && (stab_cnt == HIT_COUNT) && one_low;

  always_comb begin
    idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (sel[i]) idx = 3'(i);
    end
  end

  assign glyph    = ~{seg_q[1], seg_q[2], seg_q[3], seg_q[4], seg_q[5], seg_q[6], seg_q[7]};
  assign is_blank = (seg_q == 8'hFF);

  always_comb begin
    nib      = 4'h0;
    glyph_ok = 1'b1;
    case (glyph)
      7'h3F: nib = 4'h0;
      7'h06: nib = 4'h1;
      7'h5B: nib = 4'h2;
      7'h4F: nib = 4'h3;
      7'h66: nib = 4'h4;
      7'h6D: nib = 4'h5;
      7'h7D: nib = 4'h6;
      7'h07: nib = 4'h7;
      7'h7F: nib = 4'h8;
      7'h6F: nib = 4'h9;
      7'h77: nib = 4'hA;
      7'h7C: nib = 4'hB;
      7'h39: nib = 4'hC;
      7'h5E: nib = 4'hD;
      7'h79: nib = 4'hE;
      7'h71: nib = 4'hF;
      default: begin
        nib      = 4'h0;
        glyph_ok = 1'b0;
      end
    endcase
  end

  // A full mask publishes on the following edge; a capture on that same edge
  // belongs to the next frame.
  always_comb begin
    mask_next = (mask == 8'hFF) ? 8'h00 : mask;
    if (capture) mask_next[idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mask        <= 8'h00;
      stage_num   <= 32'h0;
      stage_pt    <= 8'h00;
      stage_blank <= 8'h00;
      err         <= 1'b0;
    end else begin
      mask <= mask_next;
      err  <= capture && !is_blank && !glyph_ok;
      if (capture) begin
        stage_num[{idx, 2'b00} +: 4] <= is_blank ? 4'h0 : nib;
        stage_pt[idx]                <= !is_blank && !seg_q[0];
        stage_blank[idx]             <= is_blank;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      disp_num    <= 32'h0;
      point       <= 8'h00;
      blank       <= 8'hFF;
      frame_valid <= 1'b0;
    end else begin
      frame_valid <= (mask == 8'hFF);
      if (mask == 8'hFF) begin
        disp_num <= stage_num;
        point    <= stage_pt;
        blank    <= stage_blank;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_seg7_capture.sv
// Directed bench for seg7_capture: expected frames are queued as stimulus is
// driven and checked whenever frame_valid pulses.
`default_nettype none

module tb_seg7_capture;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [7:0]  AN = 8'hFF;
  logic [7:0]  segment = 8'hFF;
  logic [31:0] disp_num;
  logic [7:0]  point, blank;
  logic        frame_valid, err;

  seg7_capture #(.STABLE_CYCLES(4)) dut (
    .clk(clk), .rstn(rstn), .AN(AN), .segment(segment),
    .disp_num(disp_num), .point(point), .blank(blank),
    .frame_valid(frame_valid), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] num;
    logic [7:0]  pt;
    logic [7:0]  bl;
  } frame_t;

  frame_t exp_q[$];
  int vectors = 0;
  int miscompares = 0;
  int frames_seen = 0;
  int err_seen = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [6:0] g7(input logic [3:0] n);
    case (n)
      4'h0: g7 = 7'h3F; 4'h1: g7 = 7'h06; 4'h2: g7 = 7'h5B; 4'h3: g7 = 7'h4F;
      4'h4: g7 = 7'h66; 4'h5: g7 = 7'h6D; 4'h6: g7 = 7'h7D; 4'h7: g7 = 7'h07;
      4'h8: g7 = 7'h7F; 4'h9: g7 = 7'h6F; 4'hA: g7 = 7'h77; 4'hB: g7 = 7'h7C;
      4'hC: g7 = 7'h39; 4'hD: g7 = 7'h5E; 4'hE: g7 = 7'h79; default: g7 = 7'h71;
    endcase
  endfunction

  // gfedcba active-high -> bus order a,b,c,d,e,f,g,p active-low
  function automatic logic [7:0] seg_of(input logic [6:0] g, input bit p);
    seg_of = ~{g[0], g[1], g[2], g[3], g[4], g[5], g[6], p};
  endfunction

  task automatic drive_raw(input int d, input logic [7:0] seg, input int n);
    @(negedge clk);
    AN = ~(8'h01 << d);
    segment = seg;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic drive_digit(input int d, input logic [3:0] nib, input bit p, input int n);
    drive_raw(d, seg_of(g7(nib), p), n);
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    AN = 8'hFF;
    segment = 8'hFF;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic push(input logic [31:0] num, input logic [7:0] pt, input logic [7:0] bl);
    frame_t f;
    f.num = num; f.pt = pt; f.bl = bl;
    exp_q.push_back(f);
  endtask

  task automatic wait_frames(input int target, input int budget);
    for (int i = 0; i < budget && frames_seen < target; i++) begin
      @(negedge clk);
      #1;
    end
    chk("frame_count", frames_seen, target);
  endtask

  task automatic check_reset_outputs();
    chk("rst_disp_num", disp_num, 32'h0);
    chk("rst_point", {24'h0, point}, 32'h0);
    chk("rst_blank", {24'h0, blank}, 32'hFF);
    chk("rst_frame_valid", {31'h0, frame_valid}, 32'h0);
    chk("rst_err", {31'h0, err}, 32'h0);
  endtask

  always @(negedge clk) begin
    if (rstn && err) err_seen++;
    if (rstn && frame_valid) begin
      frames_seen++;
      chk("frame_expected", {31'h0, exp_q.size() != 0}, 32'h1);
      if (exp_q.size() != 0) begin
        frame_t f;
        f = exp_q.pop_front();
        chk("disp_num", disp_num, f.num);
        chk("point", {24'h0, point}, {24'h0, f.pt});
        chk("blank", {24'h0, blank}, {24'h0, f.bl});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0, f0;
    logic [31:0] v;

    // reset state
    repeat (3) @(negedge clk);
    check_reset_outputs();
    rstn = 1'b1;
    idle(3);

    // plain frame 0x12345678
    v = 32'h12345678;
    push(v, 8'h00, 8'h00);
    for (int i = 0; i < 8; i++) drive_digit(i, v[4*i +: 4], 1'b0, 6);
    idle(2);
    wait_frames(1, 20);
    chk("no_err_plain", err_seen, 0);

    // digit 3 held too briefly: no frame until it is held long enough
    v = 32'h9ABCDEF0;
    for (int i = 0; i < 8; i++) drive_digit(i, v[4*i +: 4], 1'b0, (i == 3) ? 3 : 6);
    idle(10);
    chk("short_hold_no_frame", frames_seen, 1);
    chk("hold_disp_num", disp_num, 32'h12345678);
    push(v, 8'h00, 8'h00);
    drive_digit(3, v[15:12], 1'b0, 4);
    idle(2);
    wait_frames(2, 20);

    // blank digit 5, digit 2 shows 'A' with point lit
    v = 32'h76043A21;
    push(v, 8'h04, 8'h20);
    for (int i = 0; i < 8; i++) begin
      if (i == 5) drive_raw(i, 8'hFF, 6);
      else drive_digit(i, v[4*i +: 4], i == 2, 6);
    end
    idle(2);
    wait_frames(3, 20);
    chk("no_err_blank", err_seen, 0);

    // digit 0 shows no segments but the point: not a glyph, flags err
    e0 = err_seen;
    v = 32'hEDCBA980;
    push(v, 8'h01, 8'h00);
    drive_raw(0, 8'hFE, 6);
    for (int i = 1; i < 8; i++) drive_digit(i, v[4*i +: 4], 1'b0, 6);
    idle(2);
    wait_frames(4, 20);
    chk("err_pulse_count", err_seen, e0 + 1);

    // two digits enabled at once is ignored mid-frame
    v = 32'h89ABCDEF;
    for (int i = 0; i < 7; i++) drive_digit(i, v[4*i +: 4], 1'b0, 6);
    e0 = err_seen;
    f0 = frames_seen;
    @(negedge clk);
    AN = 8'hFC;
    segment = 8'hFE;
    repeat (9) @(negedge clk);
    chk("multi_an_no_err", err_seen, e0);
    chk("multi_an_no_frame", frames_seen, f0);
    push(v, 8'h00, 8'h00);
    drive_digit(7, v[31:28], 1'b0, 6);
    idle(2);
    wait_frames(5, 20);

    // reset after five captures discards the partial frame
    for (int i = 0; i < 5; i++) drive_digit(i, 4'h5, 1'b0, 6);
    idle(1);
    @(posedge clk);
    #2;
    rstn = 1'b0;
    #1;
    check_reset_outputs();
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 5; i < 8; i++) drive_digit(i, 4'(i - 4), 1'b0, 6);
    idle(10);
    chk("after_reset_no_frame", frames_seen, 5);
    push(32'h32144444, 8'h00, 8'h00);
    for (int i = 0; i < 5; i++) drive_digit(i, 4'h4, 1'b0, 6);
    idle(2);
    wait_frames(6, 20);
    chk("queue_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/seg7_capture.md
SEG7_CAPTURE -- requirements
Module: seg7_capture

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 4, meaning the number of consecutive clk rising edges an {AN,segment} value must be held before it is captured (legal range 2..255).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rstn, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port AN, input, 8 bits: digit enables, active-low; bit i low selects digit i.
REQ-005 SHALL have port segment, input, 8 bits: active-low segments; bit7=a, bit6=b, bit5=c, bit4=d, bit3=e, bit2=f, bit1=g, bit0=p.
REQ-006 SHALL have port disp_num, output, 32 bits: reconstructed hex value; digit i maps to bits [4i+3:4i].
REQ-007 SHALL have port point, output, 8 bits: bit i set means the decimal point of digit i was lit.
REQ-008 SHALL have port blank, output, 8 bits: bit i set means digit i had all eight segments off.
REQ-009 SHALL have port frame_valid, output, 1 bit: one-cycle pulse when disp_num, point and blank have just been updated.
REQ-010 SHALL have port err, output, 1 bit: one-cycle pulse on a capture whose a..g pattern is not a hex glyph.

Function
REQ-011 SHALL register AN and segment once; all further logic SHALL use the registered copy.
REQ-012 SHALL run a saturating stability counter that clears on any change of the registered {AN,segment} value and otherwise increments.
REQ-013 SHALL capture exactly once per stable value, on the edge where the value has been held for STABLE_CYCLES edges, and SHALL not capture again until the value changes.
REQ-014 SHALL perform a capture only when exactly one AN bit is low; all-high or multiple-low AN values SHALL be ignored, with no capture and no err pulse.
REQ-015 SHALL decode a..g (taken active-high as gfedcba) as: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71.
REQ-016 SHALL, on a capture, write the decoded nibble, the point bit (segment[0]==0) and the blank bit (segment==8'hFF) into staging registers for the selected digit, and set that digit's bit in an 8-bit capture mask.
REQ-017 SHALL, for a blank capture, stage nibble 0 and point 0, with no err pulse.
REQ-018 SHALL, for a non-blank pattern missing from the table, stage nibble 0, still set the mask bit, and pulse err in the cycle after the capture.
REQ-019 SHALL let a repeated capture of a digit already in the mask overwrite that digit's staging.
REQ-020 SHALL, on the edge after the mask reaches 8'hFF, copy staging to disp_num/point/blank, pulse frame_valid for one cycle and clear the mask in the same edge.
REQ-021 SHALL, when a capture coincides with mask completion, publish the old frame and count the new capture toward the next frame.
REQ-022 SHALL hold disp_num, point and blank unchanged between frame_valid pulses.

Reset
REQ-023 SHALL, while rstn is low, asynchronously drive disp_num=0, point=0, blank=8'hFF, frame_valid=0 and err=0, and clear the mask, counter, staging and input registers.
REQ-024 SHALL discard a partially captured frame when reset is asserted mid-frame; the first frame_valid after reset SHALL follow eight fresh digit captures.

Verification
REQ-025 SHALL be verified as follows: drive digits 0..7 with glyphs for 0x12345678, 6 cycles each, STABLE_CYCLES=4 -> one frame_valid, disp_num=32'h12345678, point=0, blank=0, no err.
REQ-026 SHALL be verified as follows: hold digit 3 pattern for only 3 cycles within an otherwise valid frame -> no capture of digit 3, no frame_valid until digit 3 is held for at least 4 cycles.
REQ-027 SHALL be verified as follows: digit 5 with segment=8'hFF and digit 2 with p lit showing 'A' -> blank=8'h20, point=8'h04, nibble5=0, nibble2=A.
REQ-028 SHALL be verified as follows: digit 0 segment pattern gfedcba=0x00 with p lit (not blank) -> one err pulse, nibble0=0, frame still completes.
REQ-029 SHALL be verified as follows: AN=8'hFC held 10 cycles -> no capture, no err, mask unchanged.
REQ-030 SHALL be verified as follows: assert rstn low after 5 digit captures -> outputs at reset values immediately; a later frame_valid appears only after 8 new captures.
